// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster.
// Each functional unit gets one holding slot for a finished result. Every
// cycle up to CDB_W held slots are granted in round-robin order (starting at
// rr_ptr_q) and their tag/value pairs are registered onto CDB lanes 0..CDB_W-1.
// Ungranted slots stay held and their FU sees fu_ready low (back-pressure).
//
// Handshake: a result moves from FU i into its slot at a rising edge when
//   fu_done_valid[i] & fu_ready[i]. fu_ready is computed from registered state
//   plus reset/squash only, so an FU may look at it without any loop through
//   its own valid. A slot whose contents are being broadcast this cycle
//   reports ready, so one FU can complete every cycle without bubbles.
module cdb_broadcaster #(
  parameter int NUM_FU = 8,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int CDB_W  = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [NUM_FU-1:0]          fu_done_valid,
  input  logic [NUM_FU*TAG_W-1:0]    fu_done_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_done_value,
  output logic [NUM_FU-1:0]          fu_ready,
  output logic [CDB_W-1:0]           cdb_valid,
  output logic [CDB_W*TAG_W-1:0]     cdb_tag,
  output logic [CDB_W*DATA_W-1:0]    cdb_value
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Slot state
  logic [NUM_FU-1:0]              held_q,       held_d;
  logic [NUM_FU-1:0][TAG_W-1:0]   slot_tag_q,   slot_tag_d;
  logic [NUM_FU-1:0][DATA_W-1:0]  slot_value_q, slot_value_d;
  logic [PTR_W-1:0]               rr_ptr_q,     rr_ptr_d;

  // Registered bus
  logic [CDB_W-1:0]               cdb_valid_q,  cdb_valid_d;
  logic [CDB_W-1:0][TAG_W-1:0]    cdb_tag_q,    cdb_tag_d;
  logic [CDB_W-1:0][DATA_W-1:0]   cdb_value_q,  cdb_value_d;

  // Arbitration results
  logic [NUM_FU-1:0]              grant;
  logic [CDB_W-1:0]               lane_used;
  logic [CDB_W-1:0][PTR_W-1:0]    lane_src;
  logic [PTR_W-1:0]               last_idx;
  logic [PTR_W-1:0]               scan_idx;
  int                             n_granted;

  // Round-robin scan from rr_ptr_q; the first CDB_W held slots fill lanes in order.
  always_comb begin
    grant     = '0;
    lane_used = '0;
    lane_src  = '0;
    last_idx  = rr_ptr_q;
    scan_idx  = '0;
    n_granted = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + j) % NUM_FU);
      if (held_q[scan_idx] && (n_granted < CDB_W)) begin
        grant[scan_idx] = 1'b1;
        for (int k = 0; k < CDB_W; k++) begin
          if (n_granted == k) begin
            lane_used[k] = 1'b1;
            lane_src[k]  = scan_idx;
          end
        end
        last_idx  = scan_idx;
        n_granted = n_granted + 1;
      end
    end
  end

  // A slot can accept when empty or being drained this cycle; never during reset/squash.
  assign fu_ready = (~held_q | grant) & {NUM_FU{~reset & ~squash}};

  // Next slot contents, bus contents and round-robin pointer.
  always_comb begin
    held_d       = held_q;
    slot_tag_d   = slot_tag_q;
    slot_value_d = slot_value_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_done_valid[i] && fu_ready[i]) begin
        held_d[i]       = 1'b1;
        slot_tag_d[i]   = fu_done_tag[i*TAG_W +: TAG_W];
        slot_value_d[i] = fu_done_value[i*DATA_W +: DATA_W];
      end else if (grant[i]) begin
        held_d[i] = 1'b0;
      end
    end
    cdb_valid_d = '0;
    cdb_tag_d   = '0;
    cdb_value_d = '0;
    for (int k = 0; k < CDB_W; k++) begin
      if (lane_used[k]) begin
        cdb_valid_d[k] = 1'b1;
        cdb_tag_d[k]   = slot_tag_q[lane_src[k]];
        cdb_value_d[k] = slot_value_q[lane_src[k]];
      end
    end
    rr_ptr_d = (|grant) ? PTR_W'((int'(last_idx) + 1) % NUM_FU) : rr_ptr_q;
  end

  // State registers: reset beats squash; squash empties slots and bus but keeps rr_ptr.
  always_ff @(posedge clock) begin
    if (reset) begin
      held_q       <= '0;
      slot_tag_q   <= '0;
      slot_value_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= '0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
    end else if (squash) begin
      held_q       <= '0;
      slot_tag_q   <= slot_tag_q;
      slot_value_q <= slot_value_q;
      rr_ptr_q     <= rr_ptr_q;
      cdb_valid_q  <= '0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
    end else begin
      held_q       <= held_d;
      slot_tag_q   <= slot_tag_d;
      slot_value_q <= slot_value_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_value_q  <= cdb_value_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Completion-side counterpart of the reservation station: collects finished results from all functional units and broadcasts up to CDB_W results per cycle on the common data bus.
- Drives the per-FU ready signals that the RS consumes for issue decisions.
- One holding slot per FU; round-robin arbitration onto CDB lanes; registered CDB outputs.
- Sits between the FU array and the RS/ROB/map-table wakeup logic.

Parameters:
NUM_FU, 8, number of FUs (index order: alu_1, alu_2, alu_3, ls_1, ls_2, mult_1, mult_2, branch)
TAG_W, 6, physical register tag width
DATA_W, 32, result value width
CDB_W, 3, CDB lanes broadcast per cycle

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
squash  in  1  mispredict flush; clears all pending completions
fu_done_valid  in  NUM_FU  FU i presents a completed result
fu_done_tag  in  NUM_FU*TAG_W  destination tag of FU i, slice i
fu_done_value  in  NUM_FU*DATA_W  result of FU i, slice i
fu_ready  out  NUM_FU  FU i may issue / present a result this cycle (feeds RS)
cdb_valid  out  CDB_W  lane k carries a valid broadcast
cdb_tag  out  CDB_W*TAG_W  tag on lane k
cdb_value  out  CDB_W*DATA_W  value on lane k

Behaviour:
- State: held[i], slot_tag[i], slot_value[i] per FU; rr_ptr (log2 NUM_FU bits); registered cdb_valid/cdb_tag/cdb_value.
- Reset (clock edge with reset=1): held all 0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0. While reset is high, fu_ready=0.
- Grant (combinational, from registered state only): scan slots circularly starting at rr_ptr. The first up to CDB_W slots with held=1 are granted, in scan order onto lanes 0,1,2.
- fu_ready[i] = (~held[i] | grant[i]) & ~reset & ~squash. There is no combinational path from fu_done_* to any output.
- Capture: at the edge, if fu_done_valid[i] & fu_ready[i], then held[i]=1 and tag/value are latched. Otherwise, if grant[i], held[i]=0. Grant and capture on the same FU in the same cycle: old value is broadcast, new value is latched, held stays 1.
- fu_done_valid[i] while fu_ready[i]=0 is ignored. The FU must hold its result until ready.
- Broadcast: at the edge, cdb lane k is loaded with the k-th granted slot. cdb_valid[k]=1 for granted lanes only. Unused lanes get valid=0, tag=0, value=0.
- Latency: done accepted at edge t is eligible for grant in cycle t+1 and appears on the CDB after edge t+1 (2 cycles from done_valid to cdb_valid). Lanes are contiguous from 0.
- rr_ptr update: if any grant, rr_ptr = (index of last granted slot + 1) mod NUM_FU. If no grant, rr_ptr is unchanged.
- Full condition: more than CDB_W slots held. Ungranted slots stay held, and their FUs see fu_ready=0 (back-pressure).
- Squash: at the edge, held all 0, cdb_valid=0 (tag/value zeroed), and incoming done on the same cycle is dropped. rr_ptr is unchanged.
- Priority: reset > squash > normal operation.

Test Plan:
1. Reset then idle: after 1 edge with reset=1, all cdb_valid=0 and fu_ready=8'hFF once reset drops. This holds for 5 idle cycles.
2. Single completion: mult_1 (i=5) done, tag=6'd17, value=32'hDEAD_BEEF at cycle 2. Required: cdb_valid=3'b001, cdb_tag lane0=17, value DEADBEEF after the cycle-3 edge. fu_ready[5]=1 throughout. rr_ptr becomes 6.
3. Oversubscription: all 8 FUs done simultaneously with tags 10..17, rr_ptr=0.
   - Broadcasts: tags {10,11,12}, then {13,14,15}, then {16,17}.
   - fu_ready: fu_ready[7:3]=0 in the cycle after capture, and each bit rises in the cycle its slot is granted.
4. Round-robin fairness: with rr_ptr=6, FUs 0,1,2,6,7 held. First broadcast is lanes {6,7,0}, then rr_ptr=1, and the next broadcast is {1,2}.
5. Back-to-back same FU: alu_1 presents tag 3 then tag 4 on consecutive cycles. Both are accepted (ready stays 1 via grant). CDB shows 3 then 4 on consecutive cycles, lane 0.
6. Squash mid-flight: 5 slots held plus alu_2 done in the same cycle as squash=1. Next cycle: cdb_valid=0, held all 0, fu_ready=8'hFF. The alu_2 result is never broadcast.
